// File: rtl/core_alu_pkg.sv
// Shared ALU definitions: op-vector encoding and the response record returned to requesters.
package core_alu_pkg;

  localparam int ALU_OP_W  = 10;
  localparam int CORE_XLEN = 64;
  localparam int CORE_TAGW = 4;

  localparam int ALU_OP_ADD  = 0;
  localparam int ALU_OP_SUB  = 1;
  localparam int ALU_OP_XOR  = 2;
  localparam int ALU_OP_OR   = 3;
  localparam int ALU_OP_AND  = 4;
  localparam int ALU_OP_SLT  = 5;
  localparam int ALU_OP_SLTU = 6;
  localparam int ALU_OP_SRL  = 7;
  localparam int ALU_OP_SLL  = 8;
  localparam int ALU_OP_SRA  = 9;

  typedef logic [ALU_OP_W-1:0] alu_op_t;

  typedef struct packed {
    logic [CORE_XLEN-1:0] result;
    logic [CORE_XLEN-1:0] add;
    logic                 eq;
    logic                 lt;
    logic                 err;
    logic [CORE_TAGW-1:0] tag;
  } alu_rsp_t;

endpackage

// File: rtl/core_pipe_exec_alu.sv
// Combinational integer ALU with RV64-style 32-bit word variants (results sign-extended).
module core_pipe_exec_alu
  import core_alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] opr_a,
  input  logic [XLEN-1:0] opr_b,
  input  logic            word,
  input  alu_op_t         op,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add,
  output logic            eq,
  output logic            lt,
  output logic            err
);

  localparam int SHW = $clog2(XLEN);

  logic            sub_mode;
  logic [XLEN-1:0] b_add;
  logic [XLEN-1:0] a_srl;
  logic [XLEN-1:0] a_sra;
  logic [XLEN-1:0] raw;
  logic [SHW-1:0]  shamt;
  logic            lt_s;
  logic            lt_u;

  // The adder subtracts for sub and for both compares, so add always shows a-b there.
  assign sub_mode = op[ALU_OP_SUB] | op[ALU_OP_SLT] | op[ALU_OP_SLTU];
  assign b_add    = sub_mode ? ~opr_b : opr_b;
  assign add      = opr_a + b_add + XLEN'(sub_mode);
  assign eq       = (opr_a == opr_b);

  assign lt_s = word ? ($signed(opr_a[31:0]) < $signed(opr_b[31:0])) : ($signed(opr_a) < $signed(opr_b));
  assign lt_u = word ? (opr_a[31:0] < opr_b[31:0]) : (opr_a < opr_b);
  assign lt   = op[ALU_OP_SLTU] ? lt_u : lt_s;

  assign shamt = word ? SHW'(opr_b[4:0]) : opr_b[SHW-1:0];
  assign a_srl = word ? {{(XLEN-32){1'b0}}, opr_a[31:0]} : opr_a;
  assign a_sra = word ? {{(XLEN-32){opr_a[31]}}, opr_a[31:0]} : opr_a;

  assign err = (op & (op - ALU_OP_W'(1))) != '0;

  always_comb begin
    raw = '0;
    if (op[ALU_OP_ADD] | op[ALU_OP_SUB])  raw = raw | add;
    if (op[ALU_OP_XOR])                   raw = raw | (opr_a ^ opr_b);
    if (op[ALU_OP_OR])                    raw = raw | (opr_a | opr_b);
    if (op[ALU_OP_AND])                   raw = raw | (opr_a & opr_b);
    if (op[ALU_OP_SLT] | op[ALU_OP_SLTU]) raw = raw | XLEN'(lt);
    if (op[ALU_OP_SRL])                   raw = raw | (a_srl >> shamt);
    if (op[ALU_OP_SLL])                   raw = raw | (opr_a << shamt);
    if (op[ALU_OP_SRA])                   raw = raw | XLEN'($signed(a_sra) >>> shamt);
  end

  assign result = err  ? '0 :
                  word ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;

endmodule

// File: rtl/core_pipe_exec_alu_rsp_slot.sv
// Single-entry response holding register; a load in the same cycle as a drain replaces the entry.
module core_pipe_exec_alu_rsp_slot #(
  parameter int W = 8
) (
  input  logic         g_clk,
  input  logic         g_reset,
  input  logic         load,
  input  logic         drain,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         elig,
  output logic [W-1:0] dout
);

  logic         full_reg;
  logic [W-1:0] data_reg;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      full_reg <= 1'b0;
      data_reg <= '0;
    end else if (load) begin
      full_reg <= 1'b1;
      data_reg <= din;
    end else if (drain) begin
      full_reg <= 1'b0;
    end
  end

  assign full = full_reg;
  assign elig = !full_reg || drain;
  assign dout = data_reg;

endmodule

// File: rtl/core_pipe_exec_alu_arb.sv
// Two-port arbiter sharing one ALU: port 0 has priority, port 1 wins after STARVE_LIMIT losses.
module core_pipe_exec_alu_arb
  import core_alu_pkg::*;
#(
  parameter int XLEN         = 64,
  parameter int TAGW         = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            p0_valid,
  output logic            p0_ready,
  input  logic [XLEN-1:0] p0_opr_a,
  input  logic [XLEN-1:0] p0_opr_b,
  input  logic            p0_word,
  input  alu_op_t         p0_op,
  input  logic [TAGW-1:0] p0_tag,
  output logic            p0_rsp_valid,
  input  logic            p0_rsp_ready,
  output logic [XLEN-1:0] p0_rsp_result,
  output logic [XLEN-1:0] p0_rsp_add,
  output logic            p0_rsp_eq,
  output logic            p0_rsp_lt,
  output logic            p0_rsp_err,
  output logic [TAGW-1:0] p0_rsp_tag,
  input  logic            p1_valid,
  output logic            p1_ready,
  input  logic [XLEN-1:0] p1_opr_a,
  input  logic [XLEN-1:0] p1_opr_b,
  input  logic            p1_word,
  input  alu_op_t         p1_op,
  input  logic [TAGW-1:0] p1_tag,
  output logic            p1_rsp_valid,
  input  logic            p1_rsp_ready,
  output logic [XLEN-1:0] p1_rsp_result,
  output logic [XLEN-1:0] p1_rsp_add,
  output logic            p1_rsp_eq,
  output logic            p1_rsp_lt,
  output logic            p1_rsp_err,
  output logic [TAGW-1:0] p1_rsp_tag
);

  localparam int RW = 2*XLEN + 3 + TAGW;

  logic [1:0]      valid;
  logic [1:0]      rsp_ready;
  logic [1:0]      elig;
  logic [1:0]      full;
  logic [1:0]      grant;
  logic            p1_pri;
  logic [3:0]      starve_cnt_reg;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] alu_add;
  logic            alu_word;
  logic            alu_eq;
  logic            alu_lt;
  logic            alu_err;
  alu_op_t         alu_op;
  logic [TAGW-1:0] alu_tag;
  logic [RW-1:0]   rsp_in;
  logic [RW-1:0]   rsp_out [2];

  assign valid     = {p1_valid, p0_valid};
  assign rsp_ready = {p1_rsp_ready, p0_rsp_ready};
  assign p1_pri    = (starve_cnt_reg == 4'(STARVE_LIMIT));

  // Each ready is written without its own valid so requesters never see a combinational loop.
  assign p1_ready = !g_reset && elig[1] && (p1_pri || !(valid[0] && elig[0]));
  assign p0_ready = !g_reset && elig[0] && !(valid[1] && elig[1] && p1_pri);
  assign grant    = {valid[1] && p1_ready, valid[0] && p0_ready};

  assign alu_a    = grant[1] ? p1_opr_a : p0_opr_a;
  assign alu_b    = grant[1] ? p1_opr_b : p0_opr_b;
  assign alu_word = grant[1] ? p1_word  : p0_word;
  assign alu_tag  = grant[1] ? p1_tag   : p0_tag;
  assign alu_op   = grant[1] ? p1_op : (grant[0] ? p0_op : '0);

  core_pipe_exec_alu #(.XLEN(XLEN)) u_alu (
    .opr_a  (alu_a),
    .opr_b  (alu_b),
    .word   (alu_word),
    .op     (alu_op),
    .result (alu_result),
    .add    (alu_add),
    .eq     (alu_eq),
    .lt     (alu_lt),
    .err    (alu_err)
  );

  assign rsp_in = {alu_result, alu_add, alu_eq, alu_lt, alu_err, alu_tag};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
      core_pipe_exec_alu_rsp_slot #(.W(RW)) u_slot (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .load    (grant[gi]),
        .drain   (rsp_ready[gi]),
        .din     (rsp_in),
        .full    (full[gi]),
        .elig    (elig[gi]),
        .dout    (rsp_out[gi])
      );
    end
  endgenerate

  assign p0_rsp_valid = full[0];
  assign p1_rsp_valid = full[1];
  assign {p0_rsp_result, p0_rsp_add, p0_rsp_eq, p0_rsp_lt, p0_rsp_err, p0_rsp_tag} = rsp_out[0];
  assign {p1_rsp_result, p1_rsp_add, p1_rsp_eq, p1_rsp_lt, p1_rsp_err, p1_rsp_tag} = rsp_out[1];

  // A port 1 wait caused only by its own full slot is not starvation, so the count holds.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      starve_cnt_reg <= '0;
    end else if (grant[1] || !valid[1]) begin
      starve_cnt_reg <= '0;
    end else if (elig[1] && !p1_pri) begin
      starve_cnt_reg <= starve_cnt_reg + 4'd1;
    end
  end

endmodule

// File: tb/tb_core_pipe_exec_alu_arb.sv
// Directed plus random bench for the two-port ALU arbiter, checked against a behavioural model.
module tb_core_pipe_exec_alu_arb;
  import core_alu_pkg::*;

  localparam int LIMIT = 4;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        p0_valid, p0_ready, p0_word, p0_rsp_valid, p0_rsp_ready, p0_rsp_eq, p0_rsp_lt, p0_rsp_err;
  logic        p1_valid, p1_ready, p1_word, p1_rsp_valid, p1_rsp_ready, p1_rsp_eq, p1_rsp_lt, p1_rsp_err;
  logic [63:0] p0_opr_a, p0_opr_b, p0_rsp_result, p0_rsp_add;
  logic [63:0] p1_opr_a, p1_opr_b, p1_rsp_result, p1_rsp_add;
  logic [9:0]  p0_op, p1_op;
  logic [3:0]  p0_tag, p1_tag, p0_rsp_tag, p1_rsp_tag;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [1:0]  m_full;
  alu_rsp_t    m_rsp [2];
  int          m_cnt;
  logic        a0, a1;
  logic [63:0] ra, rb;

  always #5 g_clk = ~g_clk;

  core_pipe_exec_alu_arb #(.XLEN(64), .TAGW(4), .STARVE_LIMIT(LIMIT)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_opr_a(p0_opr_a), .p0_opr_b(p0_opr_b),
    .p0_word(p0_word), .p0_op(p0_op), .p0_tag(p0_tag),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_ready(p0_rsp_ready), .p0_rsp_result(p0_rsp_result),
    .p0_rsp_add(p0_rsp_add), .p0_rsp_eq(p0_rsp_eq), .p0_rsp_lt(p0_rsp_lt),
    .p0_rsp_err(p0_rsp_err), .p0_rsp_tag(p0_rsp_tag),
    .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_opr_a(p1_opr_a), .p1_opr_b(p1_opr_b),
    .p1_word(p1_word), .p1_op(p1_op), .p1_tag(p1_tag),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_ready(p1_rsp_ready), .p1_rsp_result(p1_rsp_result),
    .p1_rsp_add(p1_rsp_add), .p1_rsp_eq(p1_rsp_eq), .p1_rsp_lt(p1_rsp_lt),
    .p1_rsp_err(p1_rsp_err), .p1_rsp_tag(p1_rsp_tag)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference ALU written straight from the operation definitions.
  function automatic alu_rsp_t alu_ref(input logic [63:0] a, input logic [63:0] b, input logic w,
                                       input logic [9:0] op, input logic [3:0] tag);
    alu_rsp_t           r;
    logic [63:0]        res;
    logic [31:0]        a32, b32;
    logic signed [31:0] sa32;
    int                 sh;
    logic               lt_s, lt_u;
    a32  = a[31:0];
    b32  = b[31:0];
    sa32 = a32;
    sh   = w ? int'(b[4:0]) : int'(b[5:0]);
    lt_s = w ? ($signed(a32) < $signed(b32)) : ($signed(a) < $signed(b));
    lt_u = w ? (a32 < b32) : (a < b);
    r.tag = tag;
    r.eq  = (a == b);
    r.lt  = op[ALU_OP_SLTU] ? lt_u : lt_s;
    r.add = (op[ALU_OP_SUB] || op[ALU_OP_SLT] || op[ALU_OP_SLTU]) ? a - b : a + b;
    r.err = ($countones(op) > 1);
    res = 64'd0;
    if (!r.err) begin
      if (op[ALU_OP_ADD])       res = a + b;
      else if (op[ALU_OP_SUB])  res = a - b;
      else if (op[ALU_OP_XOR])  res = a ^ b;
      else if (op[ALU_OP_OR])   res = a | b;
      else if (op[ALU_OP_AND])  res = a & b;
      else if (op[ALU_OP_SLT])  res = {63'd0, lt_s};
      else if (op[ALU_OP_SLTU]) res = {63'd0, lt_u};
      else if (op[ALU_OP_SRL])  res = w ? {32'd0, a32 >> sh} : a >> sh;
      else if (op[ALU_OP_SLL])  res = a << sh;
      else if (op[ALU_OP_SRA]) begin
        if (w) res = {32'd0, 32'(sa32 >>> sh)};
        else   res = $signed(a) >>> sh;
      end
    end
    if (w) res = {{32{res[31]}}, res[31:0]};
    r.result = res;
    return r;
  endfunction

  function automatic logic [9:0] rand_op();
    int k;
    logic [9:0] one;
    k   = $urandom_range(0, 19);
    one = 10'd1;
    if (k < 16) return one << (k % 10);
    if (k < 18) return 10'd0;
    return 10'($urandom);
  endfunction

  task automatic drive(input int p, input logic v, input logic [9:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic w, input logic [3:0] tag);
    if (p == 0) begin
      p0_valid = v; p0_op = op; p0_opr_a = a; p0_opr_b = b; p0_word = w; p0_tag = tag;
    end else begin
      p1_valid = v; p1_op = op; p1_opr_a = a; p1_opr_b = b; p1_word = w; p1_tag = tag;
    end
  endtask

  // One clock: check outputs and accepts against the model, then advance the model.
  task automatic cycle(output logic acc0, output logic acc1);
    logic     e0, e1, pri, g0, g1, rst, v1, rr0, rr1;
    alu_rsp_t n0, n1;
    #2;
    chk("p0_rsp", {p0_rsp_valid, p0_rsp_result, p0_rsp_add, p0_rsp_eq, p0_rsp_lt, p0_rsp_err, p0_rsp_tag},
        {m_full[0], m_rsp[0]});
    chk("p1_rsp", {p1_rsp_valid, p1_rsp_result, p1_rsp_add, p1_rsp_eq, p1_rsp_lt, p1_rsp_err, p1_rsp_tag},
        {m_full[1], m_rsp[1]});
    rst = g_reset; v1 = p1_valid; rr0 = p0_rsp_ready; rr1 = p1_rsp_ready;
    e0  = !m_full[0] || rr0;
    e1  = !m_full[1] || rr1;
    pri = (m_cnt == LIMIT);
    g1  = !rst && p1_valid && e1 && (pri || !(p0_valid && e0));
    g0  = !rst && p0_valid && e0 && !g1;
    acc0 = p0_valid && p0_ready;
    acc1 = p1_valid && p1_ready;
    chk("p0_accept", acc0, g0);
    chk("p1_accept", acc1, g1);
    chk("grant_onehot0", acc0 && acc1, 1'b0);
    if (rst) chk("ready_in_reset", {p0_ready, p1_ready}, 2'b00);
    n0 = alu_ref(p0_opr_a, p0_opr_b, p0_word, p0_op, p0_tag);
    n1 = alu_ref(p1_opr_a, p1_opr_b, p1_word, p1_op, p1_tag);
    if (acc0) $display("%0t acc p0 tag=%0d op=%03h w=%0d a=%h b=%h", $time, p0_tag, p0_op, p0_word, p0_opr_a, p0_opr_b);
    if (acc1) $display("%0t acc p1 tag=%0d op=%03h w=%0d a=%h b=%h", $time, p1_tag, p1_op, p1_word, p1_opr_a, p1_opr_b);
    @(posedge g_clk);
    if (rst) begin
      m_full = 2'b00; m_rsp[0] = '0; m_rsp[1] = '0; m_cnt = 0;
    end else begin
      if (g0) begin m_full[0] = 1'b1; m_rsp[0] = n0; end else if (rr0) m_full[0] = 1'b0;
      if (g1) begin m_full[1] = 1'b1; m_rsp[1] = n1; end else if (rr1) m_full[1] = 1'b0;
      if (g1 || !v1) m_cnt = 0;
      else if (e1 && m_cnt < LIMIT) m_cnt++;
    end
    #1;
  endtask

  initial begin
    g_reset = 1'b1;
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    drive(0, 1'b0, 10'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    drive(1, 1'b0, 10'd0, 64'd0, 64'd0, 1'b0, 4'd0);
    repeat (2) @(posedge g_clk);
    #1;
    m_full = 2'b00; m_rsp[0] = '0; m_rsp[1] = '0; m_cnt = 0;

    // reset state with requests pending: nothing accepted, slots empty
    drive(0, 1'b1, 10'd1, 64'd1, 64'd2, 1'b0, 4'd1);
    drive(1, 1'b1, 10'd1, 64'd3, 64'd4, 1'b0, 4'd2);
    cycle(a0, a1);
    g_reset = 1'b0;
    drive(1, 1'b0, 10'd0, 64'd0, 64'd0, 1'b0, 4'd0);

    // 1: p0 add 5+7
    drive(0, 1'b1, 10'd1 << ALU_OP_ADD, 64'd5, 64'd7, 1'b0, 4'd3);
    cycle(a0, a1);
    p0_valid = 1'b0;
    chk("t1_valid", p0_rsp_valid, 1'b1);
    chk("t1_result", p0_rsp_result, 64'd12);
    chk("t1_tag", p0_rsp_tag, 4'd3);
    chk("t1_p1_idle", p1_rsp_valid, 1'b0);
    cycle(a0, a1);

    // 2: both always valid -> p0 x4 then p1
    drive(0, 1'b1, 10'd1 << ALU_OP_XOR, 64'hF0F0, 64'h0FF0, 1'b0, 4'd4);
    drive(1, 1'b1, 10'd1 << ALU_OP_OR,  64'hA000, 64'h000B, 1'b0, 4'd5);
    for (int i = 0; i < 10; i++) begin
      cycle(a0, a1);
      chk("t2_p1_grant", a1, (i % 5) == 4);
    end

    // 3: p0 slot stalls, p1 continues each cycle
    p1_valid = 1'b0;
    p0_rsp_ready = 1'b0;
    drive(0, 1'b1, 10'd1 << ALU_OP_SUB, 64'd100, 64'd1, 1'b0, 4'd6);
    cycle(a0, a1);
    drive(0, 1'b1, 10'd1 << ALU_OP_AND, 64'hFF, 64'h0F, 1'b0, 4'd7);
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 10'd1 << ALU_OP_SLL, 64'd1, 64'(i), 1'b0, 4'(8 + i));
      cycle(a0, a1);
      chk("t3_p0_ready", p0_ready, 1'b0);
      chk("t3_p1_acc", a1, 1'b1);
    end
    p0_rsp_ready = 1'b1;
    cycle(a0, a1);
    chk("t3_refill", {p0_rsp_valid, p0_rsp_tag}, {1'b1, 4'd7});
    p0_valid = 1'b0; p1_valid = 1'b0;
    cycle(a0, a1);

    // 4: word sub and word sra
    drive(0, 1'b1, 10'd1 << ALU_OP_SUB, 64'h0000_0000_8000_0000, 64'd1, 1'b1, 4'd9);
    cycle(a0, a1);
    chk("t4_subw", p0_rsp_result, 64'h0000_0000_7FFF_FFFF);
    drive(0, 1'b1, 10'd1 << ALU_OP_SRA, 64'h0000_0000_8000_0000, 64'd4, 1'b1, 4'd10);
    cycle(a0, a1);
    chk("t4_sraw", p0_rsp_result, 64'hFFFF_FFFF_F800_0000);

    // 5: multi-hot op flags an error, next clean op clears it
    drive(0, 1'b1, (10'd1 << ALU_OP_ADD) | (10'd1 << ALU_OP_XOR), 64'd20, 64'd22, 1'b0, 4'd11);
    cycle(a0, a1);
    chk("t5_err", {p0_rsp_err, p0_rsp_result, p0_rsp_add}, {1'b1, 64'd0, 64'd42});
    drive(0, 1'b1, 10'd1 << ALU_OP_SLTU, 64'd3, 64'd9, 1'b0, 4'd12);
    cycle(a0, a1);
    chk("t5_clean", {p0_rsp_err, p0_rsp_result, p0_rsp_lt}, {1'b0, 64'd1, 1'b1});
    p0_valid = 1'b0;

    // 6a: reset with both slots full
    p1_rsp_ready = 1'b0;
    drive(1, 1'b1, 10'd1 << ALU_OP_ADD, 64'd1, 64'd1, 1'b0, 4'd13);
    cycle(a0, a1);
    p0_rsp_ready = 1'b0;
    drive(0, 1'b1, 10'd1 << ALU_OP_ADD, 64'd2, 64'd2, 1'b0, 4'd14);
    drive(1, 1'b1, 10'd1 << ALU_OP_ADD, 64'd3, 64'd3, 1'b0, 4'd15);
    cycle(a0, a1);
    chk("t6_both_full", {p0_rsp_valid, p1_rsp_valid}, 2'b11);
    g_reset = 1'b1;
    cycle(a0, a1);
    g_reset = 1'b0;
    chk("t6_reset_valid", {p0_rsp_valid, p1_rsp_valid}, 2'b00);

    // 6b: reset with starve count part way, grant pattern restarts from zero
    p0_rsp_ready = 1'b1; p1_rsp_ready = 1'b1;
    repeat (3) cycle(a0, a1);
    g_reset = 1'b1;
    cycle(a0, a1);
    g_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle(a0, a1);
      chk("t6_restart_p1", a1, i == 4);
    end

    // random traffic: payload held until accepted
    for (int i = 0; i < 400; i++) begin
      if (!p0_valid || a0) begin
        ra = {$urandom, $urandom};
        rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
        drive(0, $urandom_range(0, 3) != 0, rand_op(), ra, rb, 1'($urandom_range(0, 1)), 4'($urandom));
      end
      if (!p1_valid || a1) begin
        ra = {$urandom, $urandom};
        rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
        drive(1, $urandom_range(0, 3) != 0, rand_op(), ra, rb, 1'($urandom_range(0, 1)), 4'($urandom));
      end
      p0_rsp_ready = ($urandom_range(0, 3) != 0);
      p1_rsp_ready = ($urandom_range(0, 3) != 0);
      g_reset      = ($urandom_range(0, 99) == 0);
      cycle(a0, a1);
    end
    g_reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
